// File: rtl/fe_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fe_pkg;

    // 32-bit RV32I operand/address type used on the next-PC path.
    typedef logic [31:0] RV32I_OPERAND_t;

    // Fetch controller states.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Boot address used when no override is given.
    localparam RV32I_OPERAND_t DEFAULT_RESET_VECTOR = 32'h0040_0000;

    // addi x0, x0, 0 -- held in the instruction register out of reset.
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_word_aligned(input RV32I_OPERAND_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_register.sv
// Architectural program counter: plain 32-bit load-enable register.
module fetch_pc_register
    import fe_pkg::*;
#(
    parameter RV32I_OPERAND_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  RV32I_OPERAND_t d,
    output RV32I_OPERAND_t q
);

    // Reset to the boot vector; otherwise load the new PC when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VECTOR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch controller: requests the instruction at the held PC,
// waits for the memory response, and presents it to execute until retired.
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | request outstanding at program_counter, waiting for ready
// WAIT  | request accepted, waiting for the instruction word
// HOLD  | instruction valid for execute, waiting for retire
// FAULT | retired next-PC was misaligned; parked until reset
module instruction_fetch_unit
    import fe_pkg::*;
#(
    parameter RV32I_OPERAND_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic           clk,
    input  logic           rst,
    input  RV32I_OPERAND_t program_counter_new,
    input  logic           retire,
    output logic           imem_req_valid,
    output logic [31:0]    imem_req_addr,
    input  logic           imem_req_ready,
    input  logic           imem_rsp_valid,
    input  logic [31:0]    imem_rsp_data,
    output RV32I_OPERAND_t program_counter,
    output logic [31:0]    instruction,
    output logic           instruction_valid,
    output logic           misaligned
);

    fetch_state_t   state_q;
    fetch_state_t   state_d;
    logic           pc_load;
    logic           instr_load;
    logic [31:0]    instr_q;
    RV32I_OPERAND_t pc_q;

    fetch_pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (program_counter_new),
        .q    (pc_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register: captures the response only while waiting for it,
    // so early or stray responses in other states cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTRUCTION;
        end else if (instr_load) begin
            instr_q <= imem_rsp_data;
        end
    end

    // Next-state logic and register load enables.
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_load = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    // The PC is loaded even for a misaligned target so the
                    // bad address stays visible for debug.
                    pc_load = 1'b1;
                    if (is_word_aligned(program_counter_new)) begin
                        state_d = REQ;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Outputs decode from the registered state; handshakes are held off
    // while reset is asserted.
    always_comb begin
        imem_req_valid    = 1'b0;
        instruction_valid = 1'b0;
        misaligned        = 1'b0;
        if (!rst) begin
            imem_req_valid    = (state_q == REQ);
            instruction_valid = (state_q == HOLD);
            misaligned        = (state_q == FAULT);
        end
    end

    assign imem_req_addr   = pc_q;
    assign program_counter = pc_q;
    assign instruction     = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV  = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] program_counter_new;
    logic        retire;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        misaligned;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors;
    int          checks;
    logic [31:0] exp_pc;
    logic [31:0] last_instr;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .program_counter_new (program_counter_new),
        .retire              (retire),
        .imem_req_valid      (imem_req_valid),
        .imem_req_addr       (imem_req_addr),
        .imem_req_ready      (imem_req_ready),
        .imem_rsp_valid      (imem_rsp_valid),
        .imem_rsp_data       (imem_rsp_data),
        .program_counter     (program_counter),
        .instruction         (instruction),
        .instruction_valid   (instruction_valid),
        .misaligned          (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // One complete fetch starting in REQ: stall nready cycles, accept,
    // wait nwait cycles, respond with data; ends in HOLD.
    task automatic fetch(input logic [31:0] data, input int nready, input int nwait,
                         input bit spurious);
        exp_t e;
        retire = 1'b1;
        program_counter_new = 32'h0bad_0000;
        for (int i = 0; i < nready; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_req cyc%0d: valid=%b addr=%h ivalid=%b, want valid=1 addr=%h ivalid=0",
                         i, imem_req_valid, imem_req_addr, instruction_valid, exp_pc);
            end
            imem_req_ready = 1'b0;
            tick();
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL accept_req: valid=%b addr=%h, want valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        if (spurious) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0001;
        end
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        sb.push_back('{pc: exp_pc, instr: data});
        for (int i = 0; i < nwait; i++) begin
            checks++;
            if (imem_req_valid !== 1'b0 || instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_idle cyc%0d: valid=%b ivalid=%b, want 0 0",
                         i, imem_req_valid, instruction_valid);
            end
            tick();
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_req: valid=%b, want 0", imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hBAD0_0002;
        retire = 1'b0;
        checks++;
        if (instruction_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_valid: ivalid=%b, want 1", instruction_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty on instruction_valid");
        end else begin
            e = sb.pop_front();
            if (program_counter !== e.pc || instruction !== e.instr) begin
                errors++;
                $display("FAIL hold_data: pc=%h instr=%h, want pc=%h instr=%h",
                         program_counter, instruction, e.pc, e.instr);
            end
            last_instr = e.instr;
        end
    endtask

    // Retire from HOLD to an aligned target and check the new request.
    task automatic retire_to(input logic [31:0] target);
        program_counter_new = target;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        exp_pc = target;
        checks++;
        if (instruction_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== target) begin
            errors++;
            $display("FAIL retire_req: ivalid=%b valid=%b addr=%h, want 0 1 %h",
                     instruction_valid, imem_req_valid, imem_req_addr, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        retire = 1'b0;
        program_counter_new = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instruction_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: valid=%b ivalid=%b mis=%b, want 0 0 0",
                     imem_req_valid, instruction_valid, misaligned);
        end
        checks++;
        if (program_counter !== RV || instruction !== NOP) begin
            errors++;
            $display("FAIL reset_regs: pc=%h instr=%h, want %h %h",
                     program_counter, instruction, RV, NOP);
        end
        rst = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        exp_pc = RV;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RV || instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h ivalid=%b, want 1 %h 0",
                     imem_req_valid, imem_req_addr, instruction_valid, RV);
        end
    endtask

    task automatic test_first_fetch();
        fetch(32'h0000_0093, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        retire_to(32'h0040_0004);
        fetch(32'h0010_0113, 3, 2, 1'b1);
    endtask

    task automatic test_hold_spurious();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0003;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        checks++;
        if (instruction_valid !== 1'b1 || instruction !== last_instr || program_counter !== exp_pc) begin
            errors++;
            $display("FAIL hold_spurious: ivalid=%b instr=%h pc=%h, want 1 %h %h",
                     instruction_valid, instruction, program_counter, last_instr, exp_pc);
        end
    endtask

    task automatic test_retire();
        retire_to(32'h0040_0010);
        fetch(32'h0000_0513, 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt [3];
        logic [31:0] dat [3];
        tgt[0] = 32'h0040_0014; dat[0] = 32'h0020_0593;
        tgt[1] = 32'h0040_0100; dat[1] = 32'h00b5_0633;
        tgt[2] = 32'h0000_0000; dat[2] = 32'hfff0_0693;
        for (int i = 0; i < 3; i++) begin
            retire_to(tgt[i]);
            fetch(dat[i], i, 2 - i, 1'b0);
        end
    endtask

    task automatic test_reset_in_wait();
        retire_to(32'h0040_0020);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate: valid=%b ivalid=%b, want 0 0", imem_req_valid, instruction_valid);
        end
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0004;
        tick();
        imem_rsp_valid = 1'b0;
        exp_pc = RV;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RV || instruction !== NOP
            || instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: valid=%b addr=%h instr=%h ivalid=%b, want 1 %h %h 0",
                     imem_req_valid, imem_req_addr, instruction, instruction_valid, RV, NOP);
        end
        fetch(32'h0040_0713, 1, 0, 1'b0);
    endtask

    task automatic test_misaligned();
        program_counter_new = 32'h0040_0012;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        checks++;
        if (misaligned !== 1'b1 || program_counter !== 32'h0040_0012
            || imem_req_valid !== 1'b0 || instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: mis=%b pc=%h valid=%b ivalid=%b, want 1 00400012 0 0",
                     misaligned, program_counter, imem_req_valid, instruction_valid);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0005;
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1;
            program_counter_new = 32'h0040_0000;
            tick();
            checks++;
            if (misaligned !== 1'b1 || imem_req_valid !== 1'b0 || instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL fault_sticky cyc%0d: mis=%b valid=%b ivalid=%b, want 1 0 0",
                         i, misaligned, imem_req_valid, instruction_valid);
            end
        end
        retire = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (misaligned !== 1'b0 || program_counter !== RV) begin
            errors++;
            $display("FAIL fault_clear: mis=%b pc=%h, want 0 %h", misaligned, program_counter, RV);
        end
        rst = 1'b0;
        tick();
        exp_pc = RV;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin
            errors++;
            $display("FAIL fault_restart: valid=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, RV);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_pc = RV;
        last_instr = NOP;
        test_reset();
        test_first_fetch();
        test_stall();
        test_hold_spurious();
        test_retire();
        test_back_to_back();
        test_reset_in_wait();
        test_misaligned();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
